// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator for the ArcDVI register protocol: one {wen, addr, wdata} request per frame.
// Optional build macro SPIM_LOOPBACK_EN routes the outgoing stream back into the read path.
module spi_reg_master #(
  parameter int CLK_DIV = 4,
  parameter int TURN    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_done,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_ncs,
  output logic        spi_do,
  input  logic        spi_di,
  input  logic        loopback
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [6:0] READ_LAST = 7'(47 + TURN);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [6:0]  bit_cnt;
  logic [6:0]  last_bit;
  logic [46:0] tx_sr;
  logic [31:0] rx_sr;
  logic        is_write;
  logic        lb_q;
  logic        lb_sel;
  logic        div_done;
  logic        sample_bit;

`ifdef SPIM_LOOPBACK_EN
  assign lb_sel = loopback;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign lb_sel = 1'b0;
`endif

  assign div_done   = (div_cnt == DIV_LAST);
  assign sample_bit = lb_q ? spi_do : spi_di;

  // Handshake: a request transfers on a cycle where req_valid && req_ready; ready is high only
  // while idle and drops after the accept, so the requester may change its fields from then on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      rsp_done  <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      spi_clk   <= 1'b0;
      spi_ncs   <= 1'b1;
      spi_do    <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      last_bit  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      is_write  <= 1'b0;
      lb_q      <= 1'b0;
    end else begin
      rsp_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            state     <= S_SETUP;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            spi_ncs   <= lb_sel;
            spi_clk   <= 1'b0;
            spi_do    <= req_wen;
            tx_sr     <= {3'b000, req_addr, (req_wen ? req_wdata : 32'd0)};
            last_bit  <= req_wen ? 7'd47 : READ_LAST;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            is_write  <= req_wen;
            lb_q      <= lb_sel;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          if (div_done) begin
            div_cnt <= '0;
            state   <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_SHIFT: begin
          if (!div_done) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            if (!spi_clk) begin
              spi_clk <= 1'b1;
            end else begin
              // End of a high phase: sample MISO, then advance MOSI on the falling edge.
              spi_clk <= 1'b0;
              rx_sr   <= {rx_sr[30:0], sample_bit};
              if (bit_cnt == last_bit) begin
                state  <= S_HOLD;
                spi_do <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
                spi_do  <= tx_sr[46];
                tx_sr   <= {tx_sr[45:0], 1'b0};
              end
            end
          end
        end
        S_HOLD: begin
          if (div_done) begin
            div_cnt  <= '0;
            state    <= S_GAP;
            spi_ncs  <= 1'b1;
            rsp_done <= 1'b1;
            if (!is_write) rsp_rdata <= rx_sr;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (div_done) begin
            div_cnt   <= '0;
            state     <= S_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: directed vector table, back-to-back and reset-abort sequences,
// then randomized frames checked against a frame-level model with a behavioural SPI slave.
module tb_spi_reg_master;
  localparam int CLK_DIV = 2;
  localparam int TURN    = 8;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_done;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        spi_clk;
  logic        spi_ncs;
  logic        spi_do;
  logic        spi_di;
  logic        loopback;

  spi_reg_master #(.CLK_DIV(CLK_DIV), .TURN(TURN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_clk(spi_clk), .spi_ncs(spi_ncs), .spi_do(spi_do), .spi_di(spi_di),
    .loopback(loopback)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    logic        lb;
    logic [63:0] exp_mosi;
    logic [31:0] exp_rdata;
    int          exp_ncs;
    int          exp_lat;
    int          exp_rises;
  } vec_t;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata = '0;
  logic [63:0] slave_stream = '0;
  logic [63:0] mosi_sr = '0;
  int          rise_total = 0;

  // SPI bus monitor: MOSI is stable around every rising spi_clk edge
  always @(posedge spi_clk) begin
    mosi_sr = {mosi_sr[62:0], spi_do};
    rise_total++;
  end

  // Mode-0 slave: bit i of the frame is slave_stream[63-i], updated on falling spi_clk
  initial begin
    int idx;
    spi_di = 1'b0;
    forever begin
      @(negedge spi_ncs);
      idx = 0;
      spi_di = slave_stream[63];
      while (!spi_ncs) begin
        @(negedge spi_clk or posedge spi_ncs);
        if (!spi_ncs) begin
          idx++;
          if (idx < 64) spi_di = slave_stream[63 - idx];
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // reference model
  function automatic int frame_bits(input logic wen);
    return wen ? 48 : 48 + TURN;
  endfunction

  function automatic logic lb_active(input logic lb);
`ifdef SPIM_LOOPBACK_EN
    return lb;
`else
    return 1'b0 & lb;
`endif
  endfunction

  function automatic logic [63:0] model_mosi(input logic wen, input logic [11:0] addr,
                                             input logic [31:0] wdata);
    logic [15:0] hdr;
    hdr = {wen, 3'b000, addr};
    if (wen) return {16'd0, hdr, wdata};
    return 64'(hdr) << (TURN + 32);
  endfunction

  function automatic logic [63:0] make_slave(input logic [31:0] sdata);
    logic [63:0] s;
    s = {$urandom, $urandom};
    for (int k = 0; k < 32; k++) s[63 - (16 + TURN + k)] = sdata[31 - k];
    return s;
  endfunction

  function automatic vec_t model_vec(input logic wen, input logic [11:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] sdata, input logic lb, input logic [31:0] prev_rd);
    vec_t v;
    int   nb;
    nb = frame_bits(wen);
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.sdata = sdata; v.lb = lb;
    v.exp_mosi  = model_mosi(wen, addr, wdata);
    v.exp_rdata = wen ? prev_rd : (lb_active(lb) ? 32'd0 : sdata);
    v.exp_ncs   = lb_active(lb) ? 0 : (2 + 2 * nb) * CLK_DIV;
    v.exp_lat   = (2 + 2 * nb) * CLK_DIV + 1;
    v.exp_rises = nb;
    return v;
  endfunction

  // driver tasks
  task automatic start_req(input logic wen, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic lb, output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    ok = req_ready;
    if (!ok) begin
      check("ready_timeout", 64'(req_ready), 64'd1);
      return;
    end
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; loopback = lb;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wen = 1'($urandom); req_addr = 12'($urandom); req_wdata = $urandom; loopback = 1'($urandom);
  endtask

  // Measures one frame up to its rsp_done cycle, starting from the given counts.
  task automatic measure_check(input vec_t v, input int lat_init, input int ncs_init, input int rise_base);
    int          lat;
    int          ncs_low;
    logic [63:0] mask;
    logic [31:0] exp_rd;
    lat = lat_init;
    ncs_low = ncs_init;
    exp_rd = exp_q.pop_front();
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      if (!spi_ncs) ncs_low++;
      if (rsp_done) break;
    end
    if (!rsp_done) begin
      check("done_timeout", 64'(rsp_done), 64'd1);
      return;
    end
    mask = (64'd1 << frame_bits(v.wen)) - 64'd1;
    check("latency", 64'(lat), 64'(v.exp_lat));
    check("ncs_low_cycles", 64'(ncs_low), 64'(v.exp_ncs));
    check("sclk_rises", 64'(rise_total - rise_base), 64'(v.exp_rises));
    check("mosi_stream", mosi_sr & mask, v.exp_mosi);
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    check("busy_at_done", 64'(busy), 64'd1);
    check("ncs_at_done", 64'(spi_ncs), 64'd1);
  endtask

  task automatic run_xfer(input vec_t v);
    bit ok;
    slave_stream = make_slave(v.sdata);
    exp_q.push_back(v.exp_rdata);
    start_req(v.wen, v.addr, v.wdata, v.lb, ok);
    if (!ok) begin
      void'(exp_q.pop_front());
      return;
    end
    measure_check(v, 0, 0, rise_total);
    @(negedge clk);
    check("done_one_cycle", 64'(rsp_done), 64'd0);
  endtask

  vec_t tbl[6];

  initial begin
    vec_t        v;
    vec_t        v2;
    bit          ok;
    int          hi_cnt;
    int          w;
    int          r0;
    int          done_cnt;

    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; loopback = 1'b0;

    tbl[0] = '{1'b1, 12'h301, 32'h0000_00C0, 32'h0, 1'b0, 64'h0000_8301_0000_00C0, 32'h0, 196, 197, 48};
    tbl[1] = '{1'b0, 12'h300, 32'h0, 32'h0080_0001, 1'b0, 64'h0003_0000_0000_0000, 32'h0080_0001, 228, 229, 56};
    tbl[2] = '{1'b1, 12'hABC, 32'hDEAD_BEEF, 32'h0, 1'b0, 64'h0000_8ABC_DEAD_BEEF, 32'h0080_0001, 196, 197, 48};
`ifdef SPIM_LOOPBACK_EN
    tbl[3] = '{1'b0, 12'hFFF, 32'h0, 32'h1234_5678, 1'b1, 64'h000F_FF00_0000_0000, 32'h0, 0, 229, 56};
    tbl[5] = '{1'b1, 12'h000, 32'hFFFF_FFFF, 32'h0, 1'b1, 64'h0000_8000_FFFF_FFFF, 32'hFFFF_FFFF, 0, 197, 48};
`else
    tbl[3] = '{1'b0, 12'hFFF, 32'h0, 32'h1234_5678, 1'b1, 64'h000F_FF00_0000_0000, 32'h1234_5678, 228, 229, 56};
    tbl[5] = '{1'b1, 12'h000, 32'hFFFF_FFFF, 32'h0, 1'b1, 64'h0000_8000_FFFF_FFFF, 32'hFFFF_FFFF, 196, 197, 48};
`endif
    tbl[4] = '{1'b0, 12'h000, 32'h0, 32'hFFFF_FFFF, 1'b0, 64'h0, 32'hFFFF_FFFF, 228, 229, 56};

    // reset held three cycles
    repeat (3) @(negedge clk);
    check("reset_ncs", 64'(spi_ncs), 64'd1);
    check("reset_sclk", 64'(spi_clk), 64'd0);
    check("reset_do", 64'(spi_do), 64'd0);
    check("reset_done", 64'(rsp_done), 64'd0);
    check("reset_rdata", 64'(rsp_rdata), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // directed table
    for (int i = 0; i < 6; i++) run_xfer(tbl[i]);
    model_rdata = tbl[5].exp_rdata;

    // back-to-back write then read with req_valid held
    v  = model_vec(1'b1, 12'h2C4, 32'h5555_AAAA, 32'h0, 1'b0, model_rdata);
    v2 = model_vec(1'b0, 12'h13B, 32'h0, 32'hCAFE_0001, 1'b0, v.exp_rdata);
    slave_stream = make_slave(v2.sdata);
    exp_q.push_back(v.exp_rdata);
    exp_q.push_back(v2.exp_rdata);
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1; req_wen = 1'b1; req_addr = v.addr; req_wdata = v.wdata; loopback = 1'b0;
    @(posedge clk);
    #1;
    req_wen = 1'b0; req_addr = v2.addr; req_wdata = 32'h9999_9999;
    measure_check(v, 0, 0, rise_total);
    hi_cnt = 1;
    w = 0;
    while (w < 100) begin
      @(negedge clk);
      w++;
      if (spi_ncs) hi_cnt++;
      else break;
    end
    check("b2b_ncs_high", 64'(hi_cnt), 64'(CLK_DIV + 1));
    req_valid = 1'b0; req_addr = 12'hEEE; req_wen = 1'b1;
    measure_check(v2, 1, 1, rise_total);
    model_rdata = v2.exp_rdata;

    // reset in the middle of a write
    slave_stream = make_slave($urandom);
    start_req(1'b1, 12'h5A5, 32'h0F0F_0F0F, 1'b0, ok);
    r0 = rise_total;
    w = 0;
    while ((rise_total - r0) < 20 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("abort_reached_bit20", 64'(rise_total - r0), 64'd20);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ncs", 64'(spi_ncs), 64'd1);
    check("abort_sclk", 64'(spi_clk), 64'd0);
    check("abort_done", 64'(rsp_done), 64'd0);
    check("abort_rdata", 64'(rsp_rdata), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_done || !spi_ncs) done_cnt++;
    end
    check("abort_quiet", 64'(done_cnt), 64'd0);
    model_rdata = '0;
    run_xfer(model_vec(1'b1, 12'h5A5, 32'h0F0F_0F0F, 32'h0, 1'b0, model_rdata));
    v = model_vec(1'b0, 12'h5A5, 32'h0, 32'h8000_0003, 1'b0, model_rdata);
    run_xfer(v);
    model_rdata = v.exp_rdata;

    // randomized frames against the model
    for (int i = 0; i < 16; i++) begin
      v = model_vec(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), $urandom, $urandom,
                    ($urandom_range(0, 3) == 0), model_rdata);
      run_xfer(v);
      model_rdata = v.exp_rdata;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
